nfc_atomic_ca_latch: RTL and testbench

Atomic command/address latch generator (ACG channel 3) sitting directly downstream of the NFC command FSMs (GetFeature, SetFeature, Reset, ReadID…). It accepts one command byte or a burst of 1–5 address bytes plus a target-way mask, and drives the NAND legacy async bus (CE#, CLE, ALE, WE#, DQ) with programmable cycle timing. It returns Ready/LastStep to the command FSM; the shared Ready/LastStep vectors carry it on bit 3.

---
 rtl/nfc_pkg.sv | 29 ++
 rtl/nfc_atomic_ca_latch.sv | 181 ++++++++++++++++++
 tb/tb_nfc_atomic_ca_latch.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nfc_pkg.sv
// Shared NFC constants: ACG channel indices, NAND opcodes and command/address
// latch helpers used by the atomic generators.
package nfc_pkg;

  localparam int ACG_DIS = 1;
  localparam int ACG_CAL = 3;

  localparam logic [7:0] OP_RESET       = 8'hFF;
  localparam logic [7:0] OP_GET_FEATURE = 8'hEE;
  localparam logic [7:0] OP_SET_FEATURE = 8'hEF;
  localparam logic [7:0] OP_READ_STATUS = 8'h70;

  localparam logic [2:0] MAX_ADDR_BYTES = 3'd5;

  // Down-counter load value for a phase of the given length; 0 behaves as 1.
  function automatic logic [3:0] timing_load(input int cycles);
    if (cycles <= 1) return 4'd0;
    if (cycles >= 16) return 4'd15;
    return 4'(cycles - 1);
  endfunction

  function automatic logic [2:0] ca_byte_count(input logic is_cmd, input logic [2:0] n);
    if (is_cmd) return 3'd1;
    if (n == 3'd0) return 3'd1;
    if (n > MAX_ADDR_BYTES) return MAX_ADDR_BYTES;
    return n;
  endfunction

endpackage

// File: rtl/nfc_atomic_ca_latch.sv
// Atomic command/address latch generator: drives one command byte or up to five
// address bytes onto the NAND legacy async bus with programmable WE# timing.
module nfc_atomic_ca_latch
  import nfc_pkg::*;
#(
  parameter int NumberOfWays = 4,
  parameter int tCS_Cycles   = 2,
  parameter int tWP_Cycles   = 3,
  parameter int tWH_Cycles   = 2
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic                    iStart,
  input  logic [NumberOfWays-1:0] iTargetWay,
  input  logic                    iCASelect,
  input  logic [39:0]             iCAData,
  input  logic [15:0]             iNumOfData,
  output logic                    oReady,
  output logic                    oLastStep,
  output logic [NumberOfWays-1:0] oCE_n,
  output logic                    oCLE,
  output logic                    oALE,
  output logic                    oWE_n,
  output logic [7:0]              oDQ,
  output logic                    oDQOutEnable
);

  localparam logic [4:0] ST_IDLE    = 5'b00001;
  localparam logic [4:0] ST_SETUP   = 5'b00010;
  localparam logic [4:0] ST_WE_LOW  = 5'b00100;
  localparam logic [4:0] ST_WE_HIGH = 5'b01000;
  localparam logic [4:0] ST_DONE    = 5'b10000;

  localparam logic [3:0] TCS_LOAD = timing_load(tCS_Cycles);
  localparam logic [3:0] TWP_LOAD = timing_load(tWP_Cycles);
  localparam logic [3:0] TWH_LOAD = timing_load(tWH_Cycles);

  logic [4:0]              state_q, state_d;
  logic [3:0]              tmr_q, tmr_d;
  logic [2:0]              bytes_q, bytes_d;
  logic [39:0]             data_q, data_d;
  logic [NumberOfWays-1:0] way_q, way_d;
  logic                    cas_q, cas_d;

  logic                    ready_q, ready_d;
  logic                    last_q, last_d;
  logic [NumberOfWays-1:0] ce_n_q, ce_n_d;
  logic                    cle_q, cle_d;
  logic                    ale_q, ale_d;
  logic                    we_n_q, we_n_d;
  logic [7:0]              dq_q, dq_d;
  logic                    dqoe_q, dqoe_d;

  logic accept;
  logic tmr_done;
  logic unused_num_hi;

  assign unused_num_hi = ^iNumOfData[15:3];
  assign accept        = iStart & ready_q & (state_q == ST_IDLE);
  assign tmr_done      = (tmr_q == 4'd0);

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      tmr_q   <= 4'd0;
      bytes_q <= 3'd0;
      data_q  <= 40'd0;
      way_q   <= '0;
      cas_q   <= 1'b0;
      ready_q <= 1'b1;
      last_q  <= 1'b0;
      ce_n_q  <= '1;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
      we_n_q  <= 1'b1;
      dq_q    <= 8'h00;
      dqoe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bytes_q <= bytes_d;
      data_q  <= data_d;
      way_q   <= way_d;
      cas_q   <= cas_d;
      ready_q <= ready_d;
      last_q  <= last_d;
      ce_n_q  <= ce_n_d;
      cle_q   <= cle_d;
      ale_q   <= ale_d;
      we_n_q  <= we_n_d;
      dq_q    <= dq_d;
      dqoe_q  <= dqoe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bytes_d = bytes_q;
    data_d  = data_q;
    way_d   = way_q;
    cas_d   = cas_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          tmr_d   = TCS_LOAD;
          way_d   = iTargetWay;
          cas_d   = iCASelect;
          data_d  = iCAData;
          bytes_d = ca_byte_count(iCASelect, iNumOfData[2:0]);
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d = ST_WE_LOW;
          tmr_d   = TWP_LOAD;
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end
      ST_WE_LOW: begin
        if (tmr_done) begin
          state_d = ST_WE_HIGH;
          tmr_d   = TWH_LOAD;
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end
      ST_WE_HIGH: begin
        if (!tmr_done) begin
          tmr_d = tmr_q - 4'd1;
        end else if (bytes_q > 3'd1) begin
          state_d = ST_SETUP;
          tmr_d   = TCS_LOAD;
          data_d  = {data_q[31:0], 8'h00};
          bytes_d = bytes_q - 3'd1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bus outputs follow the current state one clock later, giving the extra
  // cycle between accept and the first setup cycle on the pins.
  always_comb begin
    ready_d = (state_q == ST_IDLE) && !accept;
    last_d  = 1'b0;
    ce_n_d  = '1;
    cle_d   = 1'b0;
    ale_d   = 1'b0;
    we_n_d  = 1'b1;
    dq_d    = 8'h00;
    dqoe_d  = 1'b0;
    case (state_q)
      ST_SETUP, ST_WE_LOW, ST_WE_HIGH: begin
        ce_n_d = ~way_q;
        cle_d  = cas_q;
        ale_d  = ~cas_q;
        dq_d   = data_q[39:32];
        dqoe_d = 1'b1;
        we_n_d = (state_q != ST_WE_LOW);
      end
      ST_DONE: last_d = 1'b1;
      default: ;
    endcase
  end

  assign oReady       = ready_q;
  assign oLastStep    = last_q;
  assign oCE_n        = ce_n_q;
  assign oCLE         = cle_q;
  assign oALE         = ale_q;
  assign oWE_n        = we_n_q;
  assign oDQ          = dq_q;
  assign oDQOutEnable = dqoe_q;

endmodule

// File: tb/tb_nfc_atomic_ca_latch.sv
// Scoreboard bench: stimulus pushes expected bus bytes and LastStep timing, a
// negedge monitor pops and compares. DUT 0 uses default timing, DUT 1 uses 1/1/1.
module tb_nfc_atomic_ca_latch;
  import nfc_pkg::*;

  typedef struct {
    int         id;
    bit         last;
    logic [7:0] dq;
    logic       cle;
    logic       ale;
    logic [3:0] ce_n;
    int         exp_cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start  [2];
  logic [3:0]  way    [2];
  logic        cas    [2];
  logic [39:0] cadata [2];
  logic [15:0] num    [2];
  logic        rdy    [2];
  logic        lst    [2];
  logic [3:0]  ce_n   [2];
  logic        cle    [2];
  logic        ale    [2];
  logic        we_n   [2];
  logic [7:0]  dq     [2];
  logic        dqoe   [2];

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_we   [2];
  int   lowcnt    [2];
  bit   after_lst [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nfc_atomic_ca_latch u_dut0 (
    .iSystemClock(clk), .iReset(rst), .iStart(start[0]), .iTargetWay(way[0]),
    .iCASelect(cas[0]), .iCAData(cadata[0]), .iNumOfData(num[0]),
    .oReady(rdy[0]), .oLastStep(lst[0]), .oCE_n(ce_n[0]), .oCLE(cle[0]),
    .oALE(ale[0]), .oWE_n(we_n[0]), .oDQ(dq[0]), .oDQOutEnable(dqoe[0])
  );

  nfc_atomic_ca_latch #(.tCS_Cycles(1), .tWP_Cycles(1), .tWH_Cycles(1)) u_dut1 (
    .iSystemClock(clk), .iReset(rst), .iStart(start[1]), .iTargetWay(way[1]),
    .iCASelect(cas[1]), .iCAData(cadata[1]), .iNumOfData(num[1]),
    .oReady(rdy[1]), .oLastStep(lst[1]), .oCE_n(ce_n[1]), .oCLE(cle[1]),
    .oALE(ale[1]), .oWE_n(we_n[1]), .oDQ(dq[1]), .oDQOutEnable(dqoe[1])
  );

  function automatic int twp(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic int per_byte(input int k);
    return (k == 0) ? (2 + 3 + 2) : (1 + 1 + 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    chk({tag, "_ready"}, rdy[k], 1);
    chk({tag, "_last"},  lst[k], 0);
    chk({tag, "_ce_n"},  ce_n[k], 4'hF);
    chk({tag, "_cle"},   cle[k], 0);
    chk({tag, "_ale"},   ale[k], 0);
    chk({tag, "_we_n"},  we_n[k], 1);
    chk({tag, "_dq"},    dq[k], 0);
    chk({tag, "_dqoe"},  dqoe[k], 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        prev_we[k]   = 1'b1;
        lowcnt[k]    = 0;
        after_lst[k] = 1'b0;
      end else begin
        if (after_lst[k]) begin
          chk("ready_after_last", rdy[k], 1);
          after_lst[k] = 1'b0;
        end
        if (we_n[k] === 1'b0) lowcnt[k]++;
        if (prev_we[k] === 1'b0 && we_n[k] === 1'b1) begin
          if (q.size() == 0 || q[0].last || q[0].id != k) begin
            total++; bad++;
            $display("FAIL unexpected_byte dut=%0d dq=%0h required=none", k, dq[k]);
          end else begin
            e = q.pop_front();
            chk("byte_dq",   dq[k], e.dq);
            chk("byte_cle",  cle[k], e.cle);
            chk("byte_ale",  ale[k], e.ale);
            chk("byte_ce_n", ce_n[k], e.ce_n);
            chk("byte_dqoe", dqoe[k], 1);
            chk("we_low_width", lowcnt[k], twp(k));
          end
          lowcnt[k] = 0;
        end
        if (lst[k] === 1'b1) begin
          if (q.size() == 0 || !q[0].last || q[0].id != k) begin
            total++; bad++;
            $display("FAIL unexpected_laststep dut=%0d cycle=%0d required=none", k, cyc);
          end else begin
            e = q.pop_front();
            chk("last_cycle", cyc, e.exp_cycle);
            chk("last_ready", rdy[k], 0);
            chk("last_cle",   cle[k], 0);
            chk("last_ale",   ale[k], 0);
            chk("last_ce_n",  ce_n[k], 4'hF);
            chk("last_dqoe",  dqoe[k], 0);
            chk("last_dq",    dq[k], 0);
          end
          after_lst[k] = 1'b1;
        end
        prev_we[k] = we_n[k];
      end
    end
  end

  task automatic wait_ready(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (rdy[k] === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL ready_timeout dut=%0d actual=0 required=1", k);
    end
  endtask

  task automatic scramble(input int k);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    way[k]    = 4'($urandom());
    cas[k]    = 1'($urandom());
    cadata[k] = r[39:0];
    num[k]    = 16'($urandom());
  endtask

  task automatic push_txn(input int k, input bit is_cmd, input logic [3:0] w,
                          input logic [39:0] d, input logic [15:0] n, input int acc);
    int   nb;
    exp_t e;
    if (is_cmd) nb = 1;
    else if (n[2:0] == 0) nb = 1;
    else if (n[2:0] > 5) nb = 5;
    else nb = int'(n[2:0]);
    for (int i = 0; i < nb; i++) begin
      e.id = k; e.last = 1'b0; e.exp_cycle = 0;
      e.dq = 8'(d >> (32 - 8 * i));
      e.cle = is_cmd; e.ale = !is_cmd; e.ce_n = ~w;
      q.push_back(e);
    end
    e.id = k; e.last = 1'b1; e.dq = 8'h00; e.cle = 1'b0; e.ale = 1'b0; e.ce_n = 4'hF;
    e.exp_cycle = acc + 1 + nb * per_byte(k);
    q.push_back(e);
  endtask

  task automatic run(input int k, input bit is_cmd, input logic [3:0] w,
                     input logic [39:0] d, input logic [15:0] n, input bit hold);
    bit ok;
    int acc;
    wait_ready(k, ok);
    if (ok) begin
      way[k] = w; cas[k] = is_cmd; cadata[k] = d; num[k] = n; start[k] = 1'b1;
      acc = cyc + 1;
      push_txn(k, is_cmd, w, d, n, acc);
      @(negedge clk);
      if (!hold) start[k] = 1'b0;
      scramble(k);
    end
  endtask

  task automatic run_random(input int k);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    run(k, 1'($urandom()), 4'($urandom()), r[39:0], 16'($urandom()), 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; way[k] = 4'h0; cas[k] = 1'b0; cadata[k] = 40'h0; num[k] = 16'h0;
    end
    repeat (2) @(negedge clk);
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset1");
    rst = 1'b0;

    run(0, 1'b1, 4'b0001, {OP_GET_FEATURE, 32'h0}, 16'h0, 1'b0);
    run(0, 1'b0, 4'b0001, 40'h01_00_00_00_00, 16'h0, 1'b0);
    run(0, 1'b0, 4'b0010, 40'h11_22_33_44_55, 16'h5, 1'b0);
    run(0, 1'b0, 4'b0010, 40'h11_22_33_44_55, 16'h7, 1'b0);
    run(0, 1'b1, 4'b0100, {OP_GET_FEATURE, 32'h0}, 16'h0, 1'b1);
    run(0, 1'b0, 4'b0100, 40'h01_00_00_00_00, 16'h1, 1'b1);
    run(0, 1'b1, 4'b0100, {OP_SET_FEATURE, 32'h0}, 16'h0, 1'b0);
    run(0, 1'b1, 4'b0000, {OP_READ_STATUS, 32'h0}, 16'h0, 1'b0);
    for (int i = 0; i < 12; i++) run_random(0);
    drain();

    // Reset during the WE# low phase of the second address byte.
    wait_ready(0, ok);
    if (ok) begin
      way[0] = 4'b1001; cas[0] = 1'b0; cadata[0] = 40'hA1_B2_C3_00_00; num[0] = 16'h3;
      start[0] = 1'b1;
      acc = cyc + 1;
      begin
        exp_t e;
        e.id = 0; e.last = 1'b0; e.dq = 8'hA1; e.cle = 1'b0; e.ale = 1'b1;
        e.ce_n = 4'b0110; e.exp_cycle = 0;
        q.push_back(e);
      end
      @(negedge clk);
      start[0] = 1'b0;
      for (int i = 0; i < 100 && cyc < acc + 11; i++) @(negedge clk);
      chk("pre_reset_we_low", we_n[0], 0);
      #2 rst = 1'b1;
      #1 check_idle_outputs(0, "midreset");
      chk("byte1_seen_byte2_not", q.size(), 0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("no_last_after_reset", q.size(), 0);
    end
    run(0, 1'b0, 4'b0011, 40'hDE_AD_BE_EF_00, 16'h4, 1'b0);
    drain();

    run(1, 1'b1, 4'b1000, {OP_RESET, 32'h0}, 16'h0, 1'b0);
    run(1, 1'b0, 4'b1000, 40'h11_22_33_44_55, 16'h6, 1'b0);
    for (int i = 0; i < 6; i++) run_random(1);
    drain();
    check_idle_outputs(0, "end0");
    check_idle_outputs(1, "end1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
